// File: rtl/sevseg_scan_driver.sv
// Time-multiplexed hex display driver: one shared decoder, double-buffered value, frame-aligned swap.
// Optional decimal-point support is enabled by defining SEVSEG_DP_EN.
module sevseg_scan_driver #(
  parameter int unsigned DIGITS           = 4,
  parameter int unsigned PRESCALE         = 50000,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic                  i_blank_lz,
`ifdef SEVSEG_DP_EN
  input  logic [DIGITS-1:0]     i_dp_in,
  output logic                  o_dp,
`endif
  output logic [6:0]            o_seg,
  output logic [DIGITS-1:0]     o_an,
  output logic                  o_frame_done
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PLast = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] ILast = IW'(DIGITS - 1);
  localparam logic [6:0] SegOff = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AnOff = {DIGITS{DIGIT_ACTIVE_LOW}};

  logic [PW-1:0]       r_presc;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_pending;
  logic                r_pending_valid;
  logic [4*DIGITS-1:0] r_display;
  logic                r_frame_done;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_an;

  logic                w_tick;
  logic                w_frame;
  logic [3:0]          w_nib;
  logic [6:0]          w_seg_act;
  logic [DIGITS-1:0]   w_an_act;
  logic [DIGITS-1:0]   w_blank_mask;
  logic                w_run;
  logic                w_blank;

  assign w_tick   = i_enable && (r_presc == PLast);
  assign w_frame  = w_tick && (r_idx == ILast);
  assign w_nib    = r_display[4*int'(r_idx) +: 4];
  assign w_an_act = DIGITS'(1) << r_idx;
  assign w_blank  = i_blank_lz && w_blank_mask[r_idx];

  // Digit k is blankable when it and every more-significant nibble are zero; digit 0 never is.
  always_comb begin
    w_blank_mask = '0;
    w_run        = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_run           = w_run & (r_display[4*k +: 4] == 4'h0);
      w_blank_mask[k] = w_run;
    end
  end

  always_comb begin
    w_seg_act = 7'h00;
    case (w_nib)
      4'h0: w_seg_act = 7'h3F;
      4'h1: w_seg_act = 7'h06;
      4'h2: w_seg_act = 7'h5B;
      4'h3: w_seg_act = 7'h4F;
      4'h4: w_seg_act = 7'h66;
      4'h5: w_seg_act = 7'h6D;
      4'h6: w_seg_act = 7'h7D;
      4'h7: w_seg_act = 7'h07;
      4'h8: w_seg_act = 7'h7F;
      4'h9: w_seg_act = 7'h6F;
      4'hA: w_seg_act = 7'h77;
      4'hB: w_seg_act = 7'h7C;
      4'hC: w_seg_act = 7'h39;
      4'hD: w_seg_act = 7'h5E;
      4'hE: w_seg_act = 7'h79;
      4'hF: w_seg_act = 7'h71;
      default: w_seg_act = 7'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_presc         <= '0;
      r_idx           <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      r_display       <= '0;
      r_frame_done    <= 1'b0;
      r_seg           <= SegOff;
      r_an            <= AnOff;
    end else begin
      if (!i_enable) begin
        r_presc <= '0;
        r_idx   <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
        r_idx   <= (r_idx == ILast) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      r_frame_done <= w_frame;

      // The swap uses the pending value from before this edge; a coincident load waits a frame.
      if (w_frame && r_pending_valid) r_display <= r_pending;
      if (i_load) begin
        r_pending       <= i_value;
        r_pending_valid <= 1'b1;
      end else if (w_frame) begin
        r_pending_valid <= 1'b0;
      end

      if (!i_enable || w_blank) r_seg <= SegOff;
      else                      r_seg <= w_seg_act ^ SegOff;
      r_an <= i_enable ? (w_an_act ^ AnOff) : AnOff;
    end
  end

`ifdef SEVSEG_DP_EN
  logic [DIGITS-1:0] r_dp_pending;
  logic [DIGITS-1:0] r_dp_display;
  logic              r_dp;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_dp_pending <= '0;
      r_dp_display <= '0;
      r_dp         <= SEG_ACTIVE_LOW;
    end else begin
      if (w_frame && r_pending_valid) r_dp_display <= r_dp_pending;
      if (i_load) r_dp_pending <= i_dp_in;
      r_dp <= i_enable ? (r_dp_display[r_idx] ^ SEG_ACTIVE_LOW) : SEG_ACTIVE_LOW;
    end
  end

  assign o_dp = r_dp;
`endif

  assign o_seg        = r_seg;
  assign o_an         = r_an;
  assign o_frame_done = r_frame_done;

endmodule

// File: doc/sevseg_scan_driver.md
Name: sevseg_scan_driver

Overview:
Parametrised, time-multiplexed multi-digit hex display driver for the common-segment 7-segment banks on the board. It replaces one combinational decoder per digit with a single shared decoder plus a scan sequencer. Display values are double-buffered and swap only at frame boundaries, so updates never tear. It supports leading-zero blanking and a global enable.

Parameters:
DIGITS, 4, number of digits scanned (1..8); value width is 4*DIGITS.
PRESCALE, 50000, clk cycles each digit is lit (>=2).
SEG_ACTIVE_LOW, 1, 1 = segment lit when driven 0.
DIGIT_ACTIVE_LOW, 1, 1 = digit selected when its enable line is 0.

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous active-low reset.
enable  in  1  1 = scanning; 0 = display dark.
load  in  1  single-cycle strobe; captures value into the pending buffer.
value  in  4*DIGITS  nibble k drives digit k; digit 0 is least significant.
blank_lz  in  1  1 = blank leading-zero digits.
seg  out  7  segments; bit0=a .. bit6=g.
an  out  DIGITS  one-hot digit enables.
frame_done  out  1  one-cycle pulse when digit DIGITS-1's slot ends.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - prescaler=0, index=0, pending=0, pending_valid=0, display=0, frame_done=0.
  - seg and an are driven to their inactive level (all off, per the polarity parameters).
- Prescaler:
  - Counts 0..PRESCALE-1 while enable=1.
  - On the cycle it equals PRESCALE-1 ("tick"), it wraps to 0 and index advances by 1, wrapping DIGITS-1 -> 0.
- Frame boundary:
  - Defined as a tick with index=DIGITS-1.
  - On that edge, frame_done=1 for exactly one cycle.
  - If pending_valid=1, display<=pending and pending_valid<=0 on the same edge.
- load:
  - pending<=value, pending_valid<=1, on any cycle, regardless of enable.
  - A later load before the boundary overwrites pending (last write wins).
  - load coincident with the boundary: the boundary copies the old pending; the new value is captured into pending with pending_valid=1 and applies at the next frame.
- Outputs:
  - seg and an are registered and reflect the index value from the previous cycle (1-cycle latency).
  - an is one-hot on the index; all other digits are inactive.
- Decode, active-high, gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Inverted when SEG_ACTIVE_LOW=1.
- Leading-zero blanking:
  - With blank_lz=1, digit k is blanked (seg all off, an still asserted) iff display nibbles DIGITS-1..k are all zero and k!=0.
  - Digit 0 is never blanked; an all-zero display shows "0".
- enable=0:
  - prescaler and index are held at 0; seg and an are inactive; frame_done=0.
  - pending/display logic still accepts load; the boundary swap does not occur.
  - When enable returns to 1, scanning restarts at digit 0 with a full PRESCALE slot.
- Reset mid-frame: takes effect on the next edge; discards pending and display.
- Widths: the prescaler is clog2(PRESCALE) bits and index is clog2(DIGITS) bits (min 1). There is no arithmetic on value.

Optional Feature:
Macro SEVSEG_DP_EN.
- Defined:
  - Adds input dp_in [DIGITS-1:0] and output dp [1].
  - dp_in is captured alongside value on load and double-buffered identically.
  - dp is registered with the same latency and polarity as seg (SEG_ACTIVE_LOW).
  - Leading-zero blanking does not suppress dp.
- Undefined: no dp ports; behaviour otherwise identical.

Test Plan:
DIGITS=4, PRESCALE=4, both polarities active-low.
1. Hold rst_n=0 for 2 cycles -> seg=7F, an=F, frame_done=0; release -> an=E (digit 0) one cycle after the first edge, seg=40 ("0").
2. load value=16'h1A3F, enable=1 -> after the next frame_done, digit slots show seg 0E(F), 30(3), 08(A), 79(1); each an pattern is low for exactly 4 cycles; frame_done period is 16 cycles.
3. blank_lz=1, value=16'h0020 -> digits 3 and 2 seg=7F with an asserted; digit 1 seg=24(2); digit 0 seg=40. value=0 -> only digit 0 lit as "0".
4. load 16'h1111, then load 16'h2222 mid-frame -> the next frame shows 2222 only, never 1111. load coincident with frame_done -> that value appears one frame later.
5. enable=0 mid-scan for 10 cycles -> an=F, seg=7F, no frame_done; enable=1 -> digit 0 lit for a full 4 cycles.
6. SEVSEG_DP_EN defined, dp_in=4'b0100, blank_lz=1, value=0 -> dp=0 (lit) during digit 2's slot despite the blanked segments; dp=1 in all other slots.
